// File: rtl/controller_interface_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | controller_interface_if : CPU read bus, poll request and pad serial lines |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface controller_interface_if;
    logic       poll;
    logic       SELECT_controller_1;
    logic       SELECT_controller_2;
    logic       cpu_rwb;
    logic [7:0] data;
    logic       data_oe;
    logic       ctrl_latch;
    logic       ctrl_clk;
    logic       ctrl_data_1;
    logic       ctrl_data_2;
    logic [7:0] buttons_1;
    logic [7:0] buttons_2;
    logic       busy;

    modport master (
        output poll, SELECT_controller_1, SELECT_controller_2, cpu_rwb,
               ctrl_data_1, ctrl_data_2,
        input  data, data_oe, ctrl_latch, ctrl_clk, buttons_1, buttons_2, busy
    );

    modport slave (
        input  poll, SELECT_controller_1, SELECT_controller_2, cpu_rwb,
               ctrl_data_1, ctrl_data_2,
        output data, data_oe, ctrl_latch, ctrl_clk, buttons_1, buttons_2, busy
    );
endinterface
`default_nettype wire

// File: rtl/controller_interface.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | controller_interface : polls two NES pads, serves snapshots at 0x7002/3   |
// | Optional macro CONTROLLER_INTERFACE_SYNC_EN adds 2-flop data sync.        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module controller_interface #(
    parameter int CLK_DIV = 6
) (
    input  wire logic              clk,
    input  wire logic              rst,
    controller_interface_if.slave  bus
);
    localparam int TIMER_W = $clog2(2 * CLK_DIV + 1);
    localparam logic [TIMER_W-1:0] LATCH_LAST = TIMER_W'(2 * CLK_DIV - 1);
    localparam logic [TIMER_W-1:0] PHASE_LAST = TIMER_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        LOW    = 3'd2,
        HIGH   = 3'd3,
        COMMIT = 3'd4
    } state_t;

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic [3:0]         bit_cnt;
    logic [7:0]         shift_1;
    logic [7:0]         shift_2;
    logic               sample_1;
    logic               sample_2;

`ifdef CONTROLLER_INTERFACE_SYNC_EN
    logic [1:0] sync_1;
    logic [1:0] sync_2;

    // Idle pad lines read as released, so the synchronizers reset high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 2'b11;
            sync_2 <= 2'b11;
        end else begin
            sync_1 <= {sync_1[0], bus.ctrl_data_1};
            sync_2 <= {sync_2[0], bus.ctrl_data_2};
        end
    end

    assign sample_1 = sync_1[1];
    assign sample_2 = sync_2[1];
`else
    assign sample_1 = bus.ctrl_data_1;
    assign sample_2 = bus.ctrl_data_2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            timer         <= '0;
            bit_cnt       <= '0;
            shift_1       <= '0;
            shift_2       <= '0;
            bus.ctrl_latch <= 1'b0;
            bus.ctrl_clk   <= 1'b1;
            bus.buttons_1  <= '0;
            bus.buttons_2  <= '0;
            bus.busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.poll) begin
                        state          <= LATCH;
                        timer          <= '0;
                        bit_cnt        <= '0;
                        bus.ctrl_latch <= 1'b1;
                        bus.busy       <= 1'b1;
                    end
                end
                LATCH: begin
                    if (timer == LATCH_LAST) begin
                        state          <= LOW;
                        timer          <= '0;
                        bus.ctrl_latch <= 1'b0;
                        bus.ctrl_clk   <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                LOW: begin
                    if (timer == PHASE_LAST) begin
                        // Pads are active-low; first bit shifted in lands in bit 0.
                        state        <= HIGH;
                        timer        <= '0;
                        bit_cnt      <= bit_cnt + 1'b1;
                        shift_1      <= {~sample_1, shift_1[7:1]};
                        shift_2      <= {~sample_2, shift_2[7:1]};
                        bus.ctrl_clk <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                HIGH: begin
                    if (timer == PHASE_LAST) begin
                        timer <= '0;
                        if (bit_cnt == 4'd8) begin
                            state <= COMMIT;
                        end else begin
                            state        <= LOW;
                            bus.ctrl_clk <= 1'b0;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                COMMIT: begin
                    state         <= IDLE;
                    bus.buttons_1 <= shift_1;
                    bus.buttons_2 <= shift_2;
                    bus.busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_oe = bus.cpu_rwb & (bus.SELECT_controller_1 | bus.SELECT_controller_2);
    assign bus.data    = bus.SELECT_controller_1 ? bus.buttons_1 :
                         bus.SELECT_controller_2 ? bus.buttons_2 : 8'h00;
endmodule
`default_nettype wire

// File: tb/tb_controller_interface.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for controller_interface: behavioural NES pad models plus snapshot/read-bus model.
module tb_controller_interface;
`ifdef CONTROLLER_INTERFACE_SYNC_EN
    localparam int CD = 3;
`else
    localparam int CD = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    controller_interface_if bus();

    controller_interface #(.CLK_DIV(CD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Pad model: parallel load while latch high, shift on ctrl_clk rise.
    logic [7:0] pad1_btn = 8'h00;
    logic [7:0] pad2_btn = 8'h00;
    logic [7:0] pad1_sr  = 8'h00;
    logic [7:0] pad2_sr  = 8'h00;

    always @(posedge bus.ctrl_clk or posedge bus.ctrl_latch) begin
        if (bus.ctrl_latch === 1'b1) begin
            pad1_sr <= pad1_btn;
            pad2_sr <= pad2_btn;
        end else begin
            pad1_sr <= {1'b0, pad1_sr[7:1]};
            pad2_sr <= {1'b0, pad2_sr[7:1]};
        end
    end

    assign bus.ctrl_data_1 = ~pad1_sr[0];
    assign bus.ctrl_data_2 = ~pad2_sr[0];

    // Waveform statistics accumulated on every falling clk edge.
    int   n_latch = 0, n_low = 0, n_fall = 0, n_busy = 0, n_busy_fall = 0;
    logic prev_clk = 1'b1, prev_busy = 1'b0;

    always @(negedge clk) begin
        if (bus.ctrl_latch === 1'b1) n_latch <= n_latch + 1;
        if (bus.ctrl_clk === 1'b0) n_low <= n_low + 1;
        if (prev_clk === 1'b1 && bus.ctrl_clk === 1'b0) n_fall <= n_fall + 1;
        if (bus.busy === 1'b1) n_busy <= n_busy + 1;
        if (prev_busy === 1'b1 && bus.busy === 1'b0) n_busy_fall <= n_busy_fall + 1;
        prev_clk  <= bus.ctrl_clk;
        prev_busy <= bus.busy;
    end

    // Committed snapshot as seen by the CPU.
    logic [7:0] m1 = 8'h00;
    logic [7:0] m2 = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic read_check(input bit s1, input bit s2, input bit rwb);
        logic [7:0] exp_data;
        bus.SELECT_controller_1 = s1;
        bus.SELECT_controller_2 = s2;
        bus.cpu_rwb             = rwb;
        #1;
        exp_data = s1 ? m1 : (s2 ? m2 : 8'h00);
        check("read_data", {24'd0, bus.data}, {24'd0, exp_data});
        check("read_oe", {31'd0, bus.data_oe}, {31'd0, rwb & (s1 | s2)});
        bus.SELECT_controller_1 = 1'b0;
        bus.SELECT_controller_2 = 1'b0;
        bus.cpu_rwb             = 1'b1;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 * CD + 100; i++) begin
            @(posedge clk); #1;
            if (bus.busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_falls(input int n, output bit ok);
        int   f = 0;
        logic p = bus.ctrl_clk;
        ok = 1'b0;
        for (int i = 0; i < 40 * CD + 100; i++) begin
            @(posedge clk); #1;
            if (p === 1'b1 && bus.ctrl_clk === 1'b0) f++;
            p = bus.ctrl_clk;
            if (f == n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("fall_timeout", 32'd0, 32'd1);
    endtask

    task automatic poll_and_check(input logic [7:0] b1, input logic [7:0] b2, input bit extra);
        int b_latch, b_low, b_fall, b_busy, b_bfall;
        bit ok;
        pad1_btn = b1;
        pad2_btn = b2;
        @(posedge clk); #1;
        b_latch = n_latch; b_low = n_low; b_fall = n_fall; b_busy = n_busy; b_bfall = n_busy_fall;
        bus.poll = 1'b1;
        @(posedge clk); #1;
        if (!extra) bus.poll = 1'b0;
        check("busy_rise", {31'd0, bus.busy}, 32'd1);
        if (extra) begin
            // Held through the first LATCH cycle, then re-pulsed in the final busy cycle.
            @(posedge clk); #1;
            bus.poll = 1'b0;
            repeat (18 * CD - 1) @(posedge clk);
            #1;
            bus.poll = 1'b1;
            @(posedge clk); #1;
            bus.poll = 1'b0;
            check("busy_after_commit_poll", {31'd0, bus.busy}, 32'd0);
        end else begin
            wait_idle(ok);
        end
        @(posedge clk); #1;
        check("busy_stays_low", {31'd0, bus.busy}, 32'd0);
        check("latch_cycles", n_latch - b_latch, 2 * CD);
        check("clk_low_pulses", n_fall - b_fall, 8);
        check("clk_low_cycles", n_low - b_low, 8 * CD);
        check("busy_cycles", n_busy - b_busy, 18 * CD + 1);
        check("busy_falls", n_busy_fall - b_bfall, 1);
        m1 = b1;
        m2 = b2;
        check("buttons_1", {24'd0, bus.buttons_1}, {24'd0, m1});
        check("buttons_2", {24'd0, bus.buttons_2}, {24'd0, m2});
    endtask

    initial begin
        bit ok;
        bus.poll                = 1'b0;
        bus.SELECT_controller_1 = 1'b0;
        bus.SELECT_controller_2 = 1'b0;
        bus.cpu_rwb             = 1'b1;

        // Asynchronous reset applied mid-cycle.
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("rst_latch", {31'd0, bus.ctrl_latch}, 32'd0);
        check("rst_clk", {31'd0, bus.ctrl_clk}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_buttons_1", {24'd0, bus.buttons_1}, 32'd0);
        check("rst_buttons_2", {24'd0, bus.buttons_2}, 32'd0);
        check("rst_data_oe", {31'd0, bus.data_oe}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Basic poll: A + Start on pad 1.
        poll_and_check(8'h09, 8'h00, 1'b0);
        read_check(1'b1, 1'b0, 1'b1);
        read_check(1'b0, 1'b1, 1'b1);
        read_check(1'b1, 1'b0, 1'b0);
        read_check(1'b1, 1'b1, 1'b1);

        // Atomicity: mid-poll read returns the previous snapshot.
        pad1_btn = 8'h80;
        pad2_btn = 8'h00;
        @(posedge clk); #1 bus.poll = 1'b1;
        @(posedge clk); #1 bus.poll = 1'b0;
        wait_falls(4, ok);
        check("mid_poll_busy", {31'd0, bus.busy}, 32'd1);
        read_check(1'b1, 1'b0, 1'b1);
        wait_idle(ok);
        m1 = 8'h80;
        m2 = 8'h00;
        read_check(1'b1, 1'b0, 1'b1);

        // Polls during LATCH and COMMIT must be ignored.
        poll_and_check(8'($urandom), 8'($urandom), 1'b1);

        // Randomized pads and random CPU accesses.
        for (int i = 0; i < 6; i++) begin
            poll_and_check(8'($urandom), 8'($urandom), 1'b0);
            for (int j = 0; j < 3; j++)
                read_check(1'($urandom), 1'($urandom), 1'($urandom));
        end

        // Reset during the 4th LOW discards the partial shift.
        pad1_btn = 8'($urandom) | 8'h01;
        pad2_btn = 8'($urandom);
        @(posedge clk); #1 bus.poll = 1'b1;
        @(posedge clk); #1 bus.poll = 1'b0;
        wait_falls(4, ok);
        #2 rst = 1'b1;
        #1;
        m1 = 8'h00;
        m2 = 8'h00;
        check("midrst_latch", {31'd0, bus.ctrl_latch}, 32'd0);
        check("midrst_clk", {31'd0, bus.ctrl_clk}, 32'd1);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_buttons_1", {24'd0, bus.buttons_1}, 32'd0);
        check("midrst_buttons_2", {24'd0, bus.buttons_2}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        read_check(1'b1, 1'b0, 1'b1);
        poll_and_check(8'h5A, 8'hC3, 1'b0);
        read_check(1'b0, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
